// File: rtl/fp64_minmax_tracker_pkg.sv
// fp64_minmax_tracker_pkg: shared FSM state, FP64 field widths and canonical quiet NaN.
package fp64_minmax_tracker_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;
  typedef enum logic [1:0] {ACCEPT, CMP, RESULT} state_e;
endpackage

// File: rtl/fp64_order_cmp.sv
// fp64_order_cmp: sign/magnitude ordering of two binary64 values with NaN detection.
module fp64_order_cmp
  import fp64_minmax_tracker_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        lt,
  output logic        eq,
  output logic        gt,
  output logic        a_nan,
  output logic        b_nan
);
  logic [62:0] a_m, b_m;
  logic a_s, b_s, ord, raw_eq, raw_lt;
  always_comb begin
    a_s = a[63];
    b_s = b[63];
    a_m = a[62:0];
    b_m = b[62:0];
    a_nan = (&a[MAN_W +: EXP_W]) & (|a[MAN_W-1:0]);
    b_nan = (&b[MAN_W +: EXP_W]) & (|b[MAN_W-1:0]);
    ord = ~a_nan & ~b_nan;
    // Zeros of either sign are equal; negative magnitudes order in reverse.
    raw_eq = (~|a_m & ~|b_m) | (a == b);
    raw_lt = (a_s != b_s) ? a_s : (a_s ? (a_m > b_m) : (a_m < b_m));
    eq = ord & raw_eq;
    lt = ord & ~raw_eq & raw_lt;
    gt = ord & ~raw_eq & ~raw_lt;
  end
endmodule

// File: rtl/fp64_minmax_tracker.sv
// fp64_minmax_tracker: tracks min, max, count and NaN presence over a binary64 sample stream.
module fp64_minmax_tracker
  import fp64_minmax_tracker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_min,
  output logic [63:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan_seen,
  output logic             out_empty
);
  state_e state_q, state_d;
  logic [63:0] data_q, data_d, min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic last_q, last_d, nan_q, nan_d, empty_q, empty_d, valid_q, valid_d;
  logic min_lt, min_eq, min_gt, min_an, min_bn;
  logic max_lt, max_eq, max_gt, max_an, max_bn;
  logic hs, reinit, unused_cmp;

  fp64_order_cmp u_cmp_min (
    .a(data_q), .b(min_q), .lt(min_lt), .eq(min_eq), .gt(min_gt), .a_nan(min_an), .b_nan(min_bn)
  );
  fp64_order_cmp u_cmp_max (
    .a(data_q), .b(max_q), .lt(max_lt), .eq(max_eq), .gt(max_gt), .a_nan(max_an), .b_nan(max_bn)
  );
  assign unused_cmp = ^{min_eq, min_gt, min_bn, max_lt, max_eq, max_an, max_bn};

  always_comb begin
    state_d = state_q;
    data_d = data_q;
    last_d = last_q;
    min_d = min_q;
    max_d = max_q;
    count_d = count_q;
    nan_d = nan_q;
    empty_d = empty_q;
    valid_d = valid_q;
    hs = valid_q & out_ready;
    reinit = clear | ((state_q == RESULT) & hs);
    if (state_q == ACCEPT && in_valid) begin
      data_d = in_data;
      last_d = in_last;
      state_d = CMP;
    end else if (state_q == CMP) begin
      state_d = last_q ? RESULT : ACCEPT;
      nan_d = nan_q | min_an;
      if (!min_an) begin
        min_d = (empty_q | min_lt) ? data_q : min_q;
        max_d = (empty_q | max_gt) ? data_q : max_q;
        count_d = (&count_q) ? count_q : count_q + 1'b1;
        empty_d = 1'b0;
      end
    end else if (state_q == RESULT) begin
      // out_valid rises one cycle into RESULT so the result appears two edges after the last accept.
      valid_d = ~hs;
    end
    if (reinit) begin
      state_d = ACCEPT;
      min_d = FP64_QNAN;
      max_d = FP64_QNAN;
      count_d = '0;
      nan_d = 1'b0;
      empty_d = 1'b1;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      data_q <= '0;
      last_q <= 1'b0;
      min_q <= FP64_QNAN;
      max_q <= FP64_QNAN;
      count_q <= '0;
      nan_q <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      last_q <= last_d;
      min_q <= min_d;
      max_q <= max_d;
      count_q <= count_d;
      nan_q <= nan_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready = (state_q == ACCEPT);
  assign out_valid = valid_q;
  assign out_min = min_q;
  assign out_max = max_q;
  assign out_count = count_q;
  assign out_nan_seen = nan_q;
  assign out_empty = empty_q;
endmodule

// File: doc/fp64_minmax_tracker.md
FP64_MINMAX_TRACKER -- requirements
Module: fp64_minmax_tracker

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 The module SHALL have parameter CNT_W, default 16: width of the sample counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data/in_last are valid.
REQ-006 in_ready  output  1  the block accepts a sample this cycle.
REQ-007 in_data  input  64  IEEE-754 binary64 sample.
REQ-008 in_last  input  1  the sample is the final one of the stream.
REQ-009 clear  input  1  synchronous abort; discards the stream.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_min, out_max  output  64 each  smallest and largest non-NaN sample.
REQ-013 out_count  output  CNT_W  number of non-NaN samples.
REQ-014 out_nan_seen  output  1  at least one NaN sample occurred.
REQ-015 out_empty  output  1  no non-NaN sample occurred.

Function
REQ-016 The FSM SHALL have states ACCEPT, CMP and RESULT.
REQ-017 in_ready SHALL be 1 only in ACCEPT.
REQ-018 A sample SHALL be accepted on in_valid & in_ready; it is registered and the FSM moves to CMP.
REQ-019 CMP SHALL take exactly one cycle: update the accumulators, then go to RESULT if the registered in_last=1, else back to ACCEPT.
REQ-020 Throughput SHALL be at most one sample per 2 cycles.
REQ-021 Latency SHALL be: in_last accepted at edge t gives out_valid=1 after edge t+2.
REQ-022 In RESULT, out_valid and all out_* SHALL be held stable until out_valid & out_ready.
REQ-023 On that handshake edge, the accumulators SHALL reinitialise and the FSM returns to ACCEPT.
REQ-024 A NaN sample (exponent all ones, mantissa nonzero) SHALL set nan_seen and SHALL NOT affect min, max or count.
REQ-025 The first non-NaN sample SHALL load both min and max.
REQ-026 Each later non-NaN sample SHALL replace min if strictly less and max if strictly greater; equal values keep the stored encoding.
REQ-027 +0 and -0 SHALL compare equal.
REQ-028 ±Inf SHALL order normally: -Inf is below every finite value and +Inf above every finite value.
REQ-029 The ordering SHALL be sign/magnitude.
REQ-030 For the ordering, when both signs are negative the larger magnitude SHALL be the smaller value.
REQ-031 count SHALL saturate at 2^CNT_W-1.
REQ-032 If no non-NaN sample occurred, out_empty SHALL be 1 and out_min = out_max = 64'h7FF8000000000000.
REQ-033 clear SHALL have priority over all other activity in any state: next state ACCEPT, accumulators reinitialised, the current sample is not accepted, and out_valid is dropped.

Reset
REQ-034 On rst_n=0 the FSM SHALL enter ACCEPT asynchronously.
REQ-035 Reset values SHALL be: in_ready=1, out_valid=0, out_min = out_max = 64'h7FF8000000000000, out_count=0, out_nan_seen=0, out_empty=1.
REQ-036 Reset mid-stream SHALL discard the partial stream with no result emitted.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, FP64_QNAN = 64'h7FF8000000000000, and the field widths (sign 1, exponent 11, mantissa 52).
REQ-038 One combinational sub-module fp64_order_cmp(a, b -> lt, eq, gt, a_nan, b_nan) SHALL implement REQ-024 to REQ-030.
REQ-039 fp64_order_cmp SHALL be instantiated twice, once against min and once against max.

Verification
REQ-040 Stream 0x401CCCCCCCCCCCCD (7.2), 0x4019333333333333 (6.3), 0xC01599999999999A (-5.4, last) -> out_min=0xC01599999999999A, out_max=0x401CCCCCCCCCCCCD, out_count=3, out_valid exactly 2 cycles after the last accept.
REQ-041 Stream 0x0000000000000000 then 0x8000000000000000 (last) -> out_min = out_max = 0x0000000000000000, out_count=2.
REQ-042 Stream 0x7FF8000000000000 then 0x3FF0000000000000 (last) -> min = max = 0x3FF0000000000000, count=1, nan_seen=1, empty=0.
REQ-043 Single sample 0x7FF8000000000000 (last) -> out_empty=1, min = max = 0x7FF8000000000000, count=0.
REQ-044 Stream 0x7FF0000000000000 (+Inf) then 0xC022000000000000 (-9.0, last), out_ready low for 5 cycles -> out_valid and outputs held stable, in_ready=0, min=0xC022000000000000, max=0x7FF0000000000000.
REQ-045 A new stream is then accepted the cycle after the handshake.
REQ-046 clear pulsed during CMP, and separately rst_n pulsed mid-stream, followed by a fresh stream 0x4022000000000000, 0x4020333333333333 (last) -> result reflects only the fresh stream: min=0x4020333333333333, max=0x4022000000000000, count=2.
